// File: rtl/ft_alu_op_scheduler.sv
// rtl/ft_alu_op_scheduler.sv - request sequencer and retry controller for the dual-channel fault-tolerant 3-bit ALU
//
// Purpose:
//   Accepts one ALU operation at a time and encodes it into the ALU input
//   code: operands, odd codeword parity and one-hot control. It holds the
//   inputs for SETTLE_CYCLES, then checks both output channels. A channel
//   passes only if its two-rail error pair reads 10. The two channels must
//   also agree on sum and carry. A failed check re-issues the operation up
//   to MAX_RETRY times. The result is then returned with a status code.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   req_valid/req_ready       request handshake; ready only while idle
//   req_a, req_b, req_op      operands and operation (00 A+B, 01 A-B, 10 B-A, 11 illegal)
//   alu_a, alu_b              registered ALU operands
//   alu_par                   odd-parity bit over {alu_a, alu_b}
//   alu_c                     one-hot ALU control C2..C0
//   alu_x, alu_xc, alu_xe     X channel sum, carry and error pair {XE1,XE0}
//   alu_y, alu_yc, alu_ye     Y channel sum, carry and error pair {YE1,YE0}
//   rsp_valid/rsp_ready       response handshake; response held until accepted
//   rsp_sum, rsp_carry        result taken from the X channel
//   rsp_status                00 ok, 01 ok after retry, 10 failed, 11 illegal op
//   rsp_retries               number of re-issues performed

module ft_alu_op_scheduler #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_a,
    input  logic [2:0] req_b,
    input  logic [1:0] req_op,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic       alu_par,
    output logic [2:0] alu_c,
    input  logic [2:0] alu_x,
    input  logic       alu_xc,
    input  logic [1:0] alu_xe,
    input  logic [2:0] alu_y,
    input  logic       alu_yc,
    input  logic [1:0] alu_ye,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_sum,
    output logic       rsp_carry,
    output logic [1:0] rsp_status,
    output logic [1:0] rsp_retries
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_OK_RETRY = 2'b01;
    localparam logic [1:0] ST_FAILED   = 2'b10;
    localparam logic [1:0] ST_ILLEGAL  = 2'b11;

    // Two-rail pair value that means "no error"; 01 is a reported error and
    // 00/11 indicate a broken checker, so anything but 10 fails the check.
    localparam logic [1:0] PAIR_OK = 2'b10;

    state_e     state_q, state_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;
    logic [1:0] retry_q, retry_d;
    logic [2:0] alu_a_q, alu_a_d;
    logic [2:0] alu_b_q, alu_b_d;
    logic       alu_par_q, alu_par_d;
    logic [2:0] alu_c_q, alu_c_d;
    logic [2:0] rsp_sum_q, rsp_sum_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic [1:0] rsp_status_q, rsp_status_d;
    logic [1:0] rsp_retries_q, rsp_retries_d;

    logic       chk_pass;
    logic [2:0] op_ctrl;

    assign chk_pass = (alu_xe == PAIR_OK) && (alu_ye == PAIR_OK) &&
                      (alu_x == alu_y) && (alu_xc == alu_yc);

    // One-hot control: the ALU negates B for A-B and negates A for B-A.
    always_comb begin
        op_ctrl = 3'b000;
        case (req_op)
            2'b00:   op_ctrl = 3'b001;
            2'b01:   op_ctrl = 3'b010;
            2'b10:   op_ctrl = 3'b100;
            default: op_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        retry_d       = retry_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_par_d     = alu_par_q;
        alu_c_d       = alu_c_q;
        rsp_sum_d     = rsp_sum_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_status_d  = rsp_status_q;
        rsp_retries_d = rsp_retries_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_op == 2'b11) begin
                        // Illegal op never reaches the ALU; its inputs keep
                        // whatever the previous operation left there.
                        rsp_sum_d     = 3'b000;
                        rsp_carry_d   = 1'b0;
                        rsp_status_d  = ST_ILLEGAL;
                        rsp_retries_d = 2'b00;
                        state_d       = ST_DONE;
                    end else begin
                        alu_a_d      = req_a;
                        alu_b_d      = req_b;
                        // Makes the 7-bit codeword {A,B,PAR} odd parity.
                        alu_par_d    = ~(^req_a ^ ^req_b);
                        alu_c_d      = op_ctrl;
                        settle_cnt_d = SETTLE_LOAD;
                        retry_d      = 2'b00;
                        state_d      = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end

            ST_CHECK: begin
                if (chk_pass) begin
                    rsp_sum_d     = alu_x;
                    rsp_carry_d   = alu_xc;
                    rsp_status_d  = (retry_q == 2'b00) ? ST_OK : ST_OK_RETRY;
                    rsp_retries_d = retry_q;
                    state_d       = ST_DONE;
                end else if (retry_q < RETRY_LIMIT) begin
                    // Re-issue: ALU inputs stay as registered, only the
                    // settle window restarts.
                    retry_d      = retry_q + 2'd1;
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = ST_SETTLE;
                end else begin
                    rsp_sum_d     = alu_x;
                    rsp_carry_d   = alu_xc;
                    rsp_status_d  = ST_FAILED;
                    rsp_retries_d = retry_q;
                    state_d       = ST_DONE;
                end
            end

            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= 4'd0;
            retry_q       <= 2'b00;
            alu_a_q       <= 3'b000;
            alu_b_q       <= 3'b000;
            alu_par_q     <= 1'b0;
            alu_c_q       <= 3'b000;
            rsp_sum_q     <= 3'b000;
            rsp_carry_q   <= 1'b0;
            rsp_status_q  <= 2'b00;
            rsp_retries_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            retry_q       <= retry_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_par_q     <= alu_par_d;
            alu_c_q       <= alu_c_d;
            rsp_sum_q     <= rsp_sum_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_status_q  <= rsp_status_d;
            rsp_retries_q <= rsp_retries_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_DONE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_par     = alu_par_q;
    assign alu_c       = alu_c_q;
    assign rsp_sum     = rsp_sum_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_retries = rsp_retries_q;

endmodule

// File: doc/ft_alu_op_scheduler.md
Name: ft_alu_op_scheduler

Overview:
- Sequencing controller in front of the dual-channel fault-tolerant 3-bit ALU.
- Accepts operation requests over a valid/ready handshake and encodes them into the ALU input code: operands, odd codeword parity and one-hot control.
- Waits a programmable settle time, then checks both output channels' two-rail error flags and cross-compares the two channels.
- On a detected error it re-issues the operation up to MAX_RETRY times, then returns the result with a status code.

Parameters:
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before sampling; legal range 1..15.
- MAX_RETRY, 2, re-issues allowed after the first attempt; legal range 0..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_a  in  3  operand A.
- req_b  in  3  operand B.
- req_op  in  2  operation: 00 = A+B, 01 = A-B, 10 = B-A, 11 = illegal.
- alu_a  out  3  ALU operand A (A2..A0).
- alu_b  out  3  ALU operand B (B2..B0).
- alu_par  out  1  ALU PAR input.
- alu_c  out  3  ALU control C2..C0.
- alu_x  in  3  X channel sum.
- alu_xc  in  1  X channel carry.
- alu_xe  in  2  X channel error pair {XE1,XE0}.
- alu_y  in  3  Y channel sum.
- alu_yc  in  1  Y channel carry.
- alu_ye  in  2  Y channel error pair {YE1,YE0}.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_sum  out  3  result taken from X channel.
- rsp_carry  out  1  carry taken from X channel.
- rsp_status  out  2  00 = OK first try, 01 = OK after retry, 10 = failed, 11 = illegal op.
- rsp_retries  out  2  number of re-issues performed.

Behaviour:
- Reset: all of the following are 0 on the cycle after rst is sampled high: state=IDLE, alu_a, alu_b, alu_par, alu_c, rsp_*, retry counter, settle counter.
- rst mid-operation aborts the operation. No response is emitted for it.
- States: IDLE, SETTLE, CHECK, DONE.
- req_ready = 1 only in IDLE. Requests arriving in any other state stall; there is no queue.
- Encoding, registered on accept:
  - alu_a = req_a, alu_b = req_b.
  - alu_c: 001 for op 00; 010 for op 01 (ALU negates B); 100 for op 10 (ALU negates A).
  - alu_par = ~(^req_a ^ ^req_b). The 7-bit codeword {A,B,PAR} has odd parity.
- IDLE, accept of op 11: do not drive the ALU (alu_* unchanged); go directly to DONE with status 11, sum 0, carry 0, retries 0.
- IDLE, accept of legal op: registers load; state goes to SETTLE; settle counter loads SETTLE_CYCLES-1; retry counter clears.
- SETTLE: decrement the counter each cycle. When the counter is 0, go to CHECK. ALU inputs are held constant throughout.
- CHECK: sample ALU outputs this cycle. pass = (alu_xe == 2'b10) && (alu_ye == 2'b10) && (alu_x == alu_y) && (alu_xc == alu_yc).
  - Error-pair meaning, as {E1,E0}: 10 = no error; 01 = error; 00 or 11 = checker fault, treated as error.
  - pass: go to DONE. rsp_sum = alu_x, rsp_carry = alu_xc, status = 00 if retries == 0 else 01.
  - fail with retries < MAX_RETRY: increment retries; go to SETTLE with counter reloaded; ALU inputs re-driven unchanged.
  - fail with retries == MAX_RETRY: go to DONE with status 10; sum/carry = X channel sample.
- DONE: rsp_valid = 1 and rsp_* held stable until rsp_ready. On rsp_valid && rsp_ready: go to IDLE and rsp_valid drops next cycle. A new request cannot be accepted in the same cycle as the response handshake.
- Latency: accept at cycle T; rsp_valid first high at T+SETTLE_CYCLES+2 (T+4 at defaults). Each retry adds SETTLE_CYCLES+1 cycles.
- Illegal op latency: rsp_valid at T+1.
- Arithmetic is not recomputed by the controller. Modulo-8 wrap and carry come from the ALU as-is.
- rsp_retries saturates by construction at MAX_RETRY.

Test Plan:
- Reset, then A=011, B=010, op 00, ALU model fault-free:
  - alu_c=001, alu_par=0.
  - rsp at T+4: sum=101, carry=0, status=00, retries=0.
- A=011, B=010, op 01:
  - alu_c=010.
  - Response: sum=001, carry=1, status=00.
- op 11 with any operands:
  - rsp_valid at T+1, status=11.
  - alu_* unchanged from previous values.
- Inject alu_xe=01 at first CHECK only:
  - One re-issue.
  - rsp at T+7, status=01, retries=1, correct sum.
- Hold alu_y != alu_x persistently with MAX_RETRY=2:
  - Three checks total.
  - Status=10, retries=2, rsp at T+10.
- Backpressure and reset:
  - rsp_ready held 0 for 5 cycles: rsp_* stable, req_ready=0.
  - Then pulse rst in SETTLE of the next operation: all outputs 0, IDLE next cycle, no response emitted.
